// File: rtl/lcd_pkg.sv
// Shared types for the LCD frame sequencer: command opcodes,
// FSM state encoding and the window-setup command table.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam int         CMD_LEN   = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ROW_RD,
    ST_ROW_LAT,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DONE
  } lcd_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_byte_t;

  function automatic lcd_byte_t cmd_entry(
    input logic [3:0] idx,
    input logic [7:0] x_end,
    input logic [7:0] y_end
  );
    lcd_byte_t b;
    b.dc   = 1'b1;
    b.data = 8'h00;
    case (idx)
      4'd0: begin
        b.dc   = 1'b0;
        b.data = CMD_CASET;
      end
      4'd4: b.data = x_end;
      4'd5: begin
        b.dc   = 1'b0;
        b.data = CMD_RASET;
      end
      4'd9: b.data = y_end;
      4'd10: begin
        b.dc   = 1'b0;
        b.data = CMD_RAMWR;
      end
      default: ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_pix_shift.sv
// Row shift register: holds one RAM row, presents the colour
// of the leftmost remaining pixel (optionally inverted).
module lcd_pix_shift
  #(
    parameter int          H_PIX    = 132,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             inv,
    input  logic [H_PIX-1:0] data,
    output logic [15:0]      color
  );

  logic [H_PIX-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {sr[H_PIX-2:0], 1'b0};
    end
  end

  assign color = (sr[H_PIX-1] ^ inv) ? FG_COLOR : BG_COLOR;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Frame scheduler: window setup bytes then RAM rows as RGB565.
// Define LCD_INVERT_EN to add the per-frame colour invert input.
module lcd_frame_sequencer
  import lcd_pkg::*;
  #(
    parameter int          H_PIX    = 132,
    parameter int          V_LINES  = 162,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
  )
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_done,
    input  logic             frame_req,
    output logic [7:0]       ram_addr,
    input  logic [H_PIX-1:0] ram_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_byte,
    output logic             tx_dc,
    output logic             busy,
    output logic             frame_done
`ifdef LCD_INVERT_EN
    ,
    input  logic             invert
`endif
  );

  localparam int PW = $clog2(H_PIX + 1);
  localparam logic [7:0]    X_END    = 8'(H_PIX - 1);
  localparam logic [7:0]    Y_END    = 8'(V_LINES - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(H_PIX - 1);
  localparam logic [3:0]    IDX_LAST = 4'(CMD_LEN - 1);

  lcd_state_e    state, state_d;
  logic [7:0]    row;
  logic [PW-1:0] pix;
  logic [3:0]    idx;
  logic          pending;
  logic          inv_q;
  logic          start, abort;
  logic          load, shift;
  logic          cmd_acc, pix_acc;
  logic [15:0]   color;
  lcd_byte_t     cmd;

  assign ram_addr = row;
  assign cmd      = cmd_entry(idx, X_END, Y_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    tx_dc      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    cmd_acc    = 1'b0;
    pix_acc    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (init_done && (frame_req || pending)) begin
          start   = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = cmd.dc;
        tx_byte  = cmd.data;
        if (tx_ready) begin
          cmd_acc = 1'b1;
          if (idx == IDX_LAST) state_d = ST_ROW_RD;
        end
      end
      ST_ROW_RD: begin
        busy    = 1'b1;
        state_d = ST_ROW_LAT;
      end
      ST_ROW_LAT: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = ST_PIX_HI;
      end
      ST_PIX_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_byte  = color[15:8];
        if (tx_ready) state_d = ST_PIX_LO;
      end
      ST_PIX_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_byte  = color[7:0];
        if (tx_ready) begin
          pix_acc = 1'b1;
          shift   = 1'b1;
          if (pix != PIX_LAST) state_d = ST_PIX_HI;
          else if (row != Y_END) state_d = ST_ROW_RD;
          else state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Losing the panel mid-frame discards the frame entirely
    if (busy && !init_done) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      row <= '0;
      pix <= '0;
    end else if (start) begin
      idx <= '0;
      row <= '0;
      pix <= '0;
    end else begin
      if (cmd_acc) idx <= idx + 4'd1;
      if (pix_acc) begin
        if (pix == PIX_LAST) begin
          pix <= '0;
          row <= row + 8'd1;
        end else begin
          pix <= pix + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (abort || start) begin
      pending <= 1'b0;
    end else if (frame_req) begin
      pending <= 1'b1;
    end
  end

`ifdef LCD_INVERT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (start) begin
      inv_q <= invert;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

  lcd_pix_shift #(
    .H_PIX    (H_PIX),
    .FG_COLOR (FG_COLOR),
    .BG_COLOR (BG_COLOR)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .inv   (inv_q),
    .data  (ram_data),
    .color (color)
  );

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: a full-size instance and a small
// 8x3 instance, both checked every cycle against a byte-stream model.
module tb_lcd_frame_sequencer;

  localparam int HA = 132;
  localparam int VA = 162;
  localparam int HB = 8;
  localparam int VB = 3;
  localparam int TOT_A = 11 + 2 * HA * VA;
  localparam int TOT_B = 11 + 2 * HB * VB;
  localparam logic [15:0] FG_B = 16'hF81F;
  localparam logic [15:0] BG_B = 16'h07E0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          init_a, req_a, ready_a;
  logic [7:0]    addr_a, byte_a;
  logic [HA-1:0] data_a;
  logic          valid_a, dc_a, busy_a, done_a;

  logic          init_b, req_b, ready_b;
  logic          ready_b_fix, rnd_bit, rnd_en;
  logic [7:0]    addr_b, byte_b;
  logic [HB-1:0] data_b;
  logic          valid_b, dc_b, busy_b, done_b;
  logic          inv_b;
  logic          m_inv_b;

  int n_vec = 0;
  int n_err = 0;
  int a_cnt = 0;
  int b_cnt = 0;
  int a_done = 0;
  int b_done = 0;
  logic       a_hold = 1'b0;
  logic       b_hold = 1'b0;
  logic [8:0] a_prev, b_prev;
  logic [8:0] a_log[$];
  logic [8:0] b_log[$];

  function automatic logic [131:0] ram_a(input int r);
    logic [131:0] d;
    d = '0;
    if (r == 0) d[131] = 1'b1;
    return d;
  endfunction

  function automatic logic [131:0] ram_b(input int r);
    logic [131:0] d;
    d = '0;
    case (r)
      0: d[7:0] = 8'hA5;
      1: d[7:0] = 8'h3C;
      2: d[7:0] = 8'h81;
      default: ;
    endcase
    return d;
  endfunction

  function automatic int prow(input int n, input int h);
    return (n < 11) ? 0 : ((n - 11) / 2) / h;
  endfunction

  // Byte n of a frame as {dc, byte}, from the frame layout alone
  function automatic logic [8:0] model(
    input int n, input int h, input int v,
    input logic [15:0] on_c, input logic [15:0] off_c,
    input logic [131:0] bits
  );
    int m, c;
    logic [15:0] col;
    case (n)
      0: return {1'b0, 8'h2A};
      4: return {1'b1, 8'(h - 1)};
      5: return {1'b0, 8'h2B};
      9: return {1'b1, 8'(v - 1)};
      10: return {1'b0, 8'h2C};
      1, 2, 3, 6, 7, 8: return {1'b1, 8'h00};
      default: ;
    endcase
    m = n - 11;
    c = (m / 2) % h;
    col = bits[h - 1 - c] ? on_c : off_c;
    return (m % 2 == 0) ? {1'b1, col[15:8]} : {1'b1, col[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  assign data_a  = ram_a(int'(addr_a));
  assign data_b  = 8'(ram_b(int'(addr_b)));
  assign ready_b = rnd_en ? rnd_bit : ready_b_fix;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 9) < 3);
  end

  lcd_frame_sequencer u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_a),
    .frame_req  (req_a),
    .ram_addr   (addr_a),
    .ram_data   (data_a),
    .tx_valid   (valid_a),
    .tx_ready   (ready_a),
    .tx_byte    (byte_a),
    .tx_dc      (dc_a),
    .busy       (busy_a),
    .frame_done (done_a)
`ifdef LCD_INVERT_EN
    ,
    .invert     (1'b0)
`endif
  );

  lcd_frame_sequencer #(
    .H_PIX    (HB),
    .V_LINES  (VB),
    .FG_COLOR (FG_B),
    .BG_COLOR (BG_B)
  ) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_b),
    .frame_req  (req_b),
    .ram_addr   (addr_b),
    .ram_data   (data_b),
    .tx_valid   (valid_b),
    .tx_ready   (ready_b),
    .tx_byte    (byte_b),
    .tx_dc      (dc_b),
    .busy       (busy_b),
    .frame_done (done_b)
`ifdef LCD_INVERT_EN
    ,
    .invert     (inv_b)
`endif
  );

  always @(negedge clk) begin
    logic [8:0] e;
    logic [15:0] on_c, off_c;
    if (rst_n) begin
      if (valid_a) begin
        e = model(a_cnt, HA, VA, 16'hFFFF, 16'h0000,
                  ram_a(prow(a_cnt, HA)));
        chk("a_byte", 32'({dc_a, byte_a}), 32'(e));
        if (a_cnt >= 11)
          chk("a_ram_addr", 32'(addr_a), 32'(prow(a_cnt, HA)));
      end
      if (a_hold)
        chk("a_hold", 32'({valid_a, dc_a, byte_a}), 32'({1'b1, a_prev}));
      a_hold = valid_a && !ready_a;
      a_prev = {dc_a, byte_a};
      if (valid_a && ready_a) begin
        if (a_log.size() < 16) a_log.push_back({dc_a, byte_a});
        a_cnt++;
      end
      if (done_a) begin
        chk("a_frame_len", 32'(a_cnt), 32'(TOT_A));
        chk("a_done_busy", 32'(busy_a), 32'd0);
        a_done++;
      end
      if (!busy_a) begin
        chk("a_idle_valid", 32'(valid_a), 32'd0);
        a_cnt = 0;
      end

      on_c  = m_inv_b ? BG_B : FG_B;
      off_c = m_inv_b ? FG_B : BG_B;
      if (valid_b) begin
        e = model(b_cnt, HB, VB, on_c, off_c, ram_b(prow(b_cnt, HB)));
        chk("b_byte", 32'({dc_b, byte_b}), 32'(e));
        if (b_cnt >= 11)
          chk("b_ram_addr", 32'(addr_b), 32'(prow(b_cnt, HB)));
      end
      if (b_hold)
        chk("b_hold", 32'({valid_b, dc_b, byte_b}), 32'({1'b1, b_prev}));
      b_hold = valid_b && !ready_b;
      b_prev = {dc_b, byte_b};
      if (valid_b && ready_b) begin
        if (b_log.size() < 16) b_log.push_back({dc_b, byte_b});
        b_cnt++;
      end
      if (done_b) begin
        chk("b_frame_len", 32'(b_cnt), 32'(TOT_B));
        chk("b_done_busy", 32'(busy_b), 32'd0);
        b_done++;
      end
      if (!busy_b) begin
        chk("b_idle_valid", 32'(valid_b), 32'd0);
        b_cnt = 0;
      end
    end
  end

  task automatic pulse_a();
    @(posedge clk); #1 req_a = 1'b1;
    @(posedge clk); #1 req_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 req_b = 1'b1;
    @(posedge clk); #1 req_b = 1'b0;
  endtask

  task automatic wait_done_b(input string nm);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b) break;
    end
    chk(nm, 32'(done_b), 32'd1);
  endtask

  initial begin
    int base, gap, extra, t;
    rst_n = 1'b0;
    init_a = 1'b0; req_a = 1'b0; ready_a = 1'b0;
    init_b = 1'b0; req_b = 1'b0; ready_b_fix = 1'b0;
    rnd_en = 1'b0; inv_b = 1'b0; m_inv_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'({valid_a, valid_b}), 32'd0);
    chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    chk("rst_done", 32'({done_a, done_b}), 32'd0);
    chk("rst_addr", 32'({addr_a, addr_b}), 32'd0);
    chk("rst_byte", 32'({dc_a, byte_a, dc_b, byte_b}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    init_a = 1'b1; ready_a = 1'b1;
    init_b = 1'b1; ready_b_fix = 1'b1;

    // Full-size frame, row 0 leftmost pixel lit
    a_log.delete();
    pulse_a();
    for (int i = 0; i < 50000 && a_done < 1; i++) @(negedge clk);
    chk("a_frame_count", 32'(a_done), 32'd1);
    chk("a_log_len", 32'(a_log.size()), 32'd16);
    if (a_log.size() >= 14) begin
      chk("a_b0", 32'(a_log[0]), 32'h02A);
      chk("a_b1", 32'(a_log[1]), 32'h100);
      chk("a_b4", 32'(a_log[4]), 32'h183);
      chk("a_b5", 32'(a_log[5]), 32'h02B);
      chk("a_b9", 32'(a_log[9]), 32'h1A1);
      chk("a_b10", 32'(a_log[10]), 32'h02C);
      chk("a_b11", 32'(a_log[11]), 32'h1FF);
      chk("a_b12", 32'(a_log[12]), 32'h1FF);
      chk("a_b13", 32'(a_log[13]), 32'h100);
    end

    // Abort after 100 pixel bytes, then restart
    pulse_a();
    for (int i = 0; i < 500 && a_cnt < 111; i++) @(negedge clk);
    chk("a_reach_111", 32'(a_cnt >= 111), 32'd1);
    @(posedge clk); #1 init_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("a_abort_valid", 32'(valid_a), 32'd0);
    chk("a_abort_busy", 32'(busy_a), 32'd0);
    base = a_done;
    repeat (20) @(negedge clk);
    chk("a_abort_no_done", 32'(a_done), 32'(base));
    chk("a_abort_idle", 32'(busy_a), 32'd0);
    @(posedge clk); #1 init_a = 1'b1;
    a_log.delete();
    pulse_a();
    for (int i = 0; i < 50 && a_log.size() < 5; i++) @(negedge clk);
    chk("a_restart_len", 32'(a_log.size() >= 5), 32'd1);
    if (a_log.size() >= 5) begin
      chk("a_restart_b0", 32'(a_log[0]), 32'h02A);
      chk("a_restart_b4", 32'(a_log[4]), 32'h183);
    end
    @(posedge clk); #1 init_a = 1'b0;

    // Small instance, random backpressure
    rnd_en = 1'b1;
    b_log.delete();
    pulse_b();
    wait_done_b("b_rand_done");
    rnd_en = 1'b0;
    chk("b_log_len", 32'(b_log.size()), 32'd16);
    if (b_log.size() >= 15) begin
      chk("b_b4", 32'(b_log[4]), 32'h107);
      chk("b_b9", 32'(b_log[9]), 32'h102);
      chk("b_b11", 32'(b_log[11]), 32'h1F8);
      chk("b_b12", 32'(b_log[12]), 32'h11F);
      chk("b_b13", 32'(b_log[13]), 32'h107);
      chk("b_b14", 32'(b_log[14]), 32'h1E0);
    end

    // Three requests mid-frame collapse into one extra frame
    repeat (5) @(negedge clk);
    base = b_done;
    pulse_b();
    repeat (10) @(negedge clk);
    pulse_b();
    repeat (5) @(negedge clk);
    pulse_b();
    repeat (5) @(negedge clk);
    pulse_b();
    wait_done_b("b_multi_done1");
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_b) break;
      gap++;
    end
    chk("b_idle_gap", 32'(gap), 32'd1);
    wait_done_b("b_multi_done2");
    extra = 0;
    repeat (150) begin
      @(negedge clk);
      if (done_b) extra++;
    end
    chk("b_no_third", 32'(extra), 32'd0);
    chk("b_multi_frames", 32'(b_done - base), 32'd2);
    chk("b_multi_idle", 32'(busy_b), 32'd0);

    // Request held pending until init_done rises
    @(posedge clk); #1 init_b = 1'b0;
    pulse_b();
    repeat (10) @(negedge clk);
    chk("b_pend_wait", 32'(busy_b), 32'd0);
    @(posedge clk); #1 init_b = 1'b1;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_b) break;
      t++;
    end
    chk("b_pend_start", 32'(t), 32'd1);
    wait_done_b("b_pend_done");

`ifdef LCD_INVERT_EN
    // Invert latched at start, toggled mid-frame
    repeat (5) @(negedge clk);
    @(posedge clk); #1 inv_b = 1'b1; m_inv_b = 1'b1;
    b_log.delete();
    pulse_b();
    repeat (25) @(negedge clk);
    @(posedge clk); #1 inv_b = 1'b0;
    wait_done_b("b_inv_done");
    if (b_log.size() >= 13) begin
      chk("b_inv_b11", 32'(b_log[11]), 32'h107);
      chk("b_inv_b12", 32'(b_log[12]), 32'h1E0);
    end
    @(posedge clk); #1 m_inv_b = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
